// File: rtl/event_change_monitor.sv
// ----------------------------------------------------------------------------
// event_change_monitor
//   Samples an event vector on every rising clock edge. Each change in value
//   becomes one 64-bit update record. The first cycle after reset always
//   produces a record, which acts as a snapshot of the initial value.
//   Records are queued in a small FIFO and offered downstream on a
//   valid/ready port. A sticky overflow flag shows that a record was dropped
//   because the FIFO was full.
// ----------------------------------------------------------------------------
module event_change_monitor #(
    parameter int WIDTH      = 32,  // event vector width, 1..64
    parameter int FIFO_DEPTH = 4    // power of two, 2..16
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic [WIDTH-1:0] ev,
    output logic             upd_valid,
    output logic [63:0]      upd_data,
    input  logic             upd_ready,
    output logic [4:0]       upd_count,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [63:0]      ev_q;          // last value that was reported or dropped
    logic             first_q;       // set for the first cycle after reset
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------------
    // Zero extension of the sampled vector and of the FIFO head
    // ------------------------------------------------------------------------
    logic [63:0] ev_ext;
    logic [63:0] head_ext;

    generate
        if (WIDTH < 64) begin : g_ext
            assign ev_ext   = {{(64-WIDTH){1'b0}}, ev};
            assign head_ext = {{(64-WIDTH){1'b0}}, mem_q[rd_ptr_q]};
        end else begin : g_noext
            assign ev_ext   = ev;
            assign head_ext = mem_q[rd_ptr_q];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Handshake and FIFO control terms
    // ------------------------------------------------------------------------
    logic empty;
    logic full;
    logic push;     // a change (or the initial snapshot) was seen this cycle
    logic pop;      // consumer takes the head entry this cycle
    logic accept;   // push is written into the FIFO
    logic drop;     // push is lost because the FIFO is full and not draining

    assign empty  = (count_q == 5'd0);
    assign full   = (count_q == DEPTH_C);
    assign push   = first_q | (ev_ext != ev_q);
    assign pop    = !empty && upd_ready;
    // A pop on a full FIFO frees a slot in the same cycle, so the push still fits.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    // Next-state for pointers, occupancy and the sticky overflow flag
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        // A drop on the same edge as a clear wins, so no loss goes unseen.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    // Control registers: change detector, pointers, occupancy, overflow
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_q       <= '0;
            first_q    <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // A dropped value still updates the reference, so it is never re-reported.
            if (push) begin
                ev_q <= ev_ext;
            end
            first_q    <= 1'b0;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write port
    // NOTE: the storage array has no reset; entries are only visible through
    // count_q, which is reset, so stale contents can never reach the output.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= ev;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign upd_valid = !empty;
    assign upd_data  = empty ? 64'd0 : head_ext;
    assign upd_count = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_event_change_monitor.sv
// ----------------------------------------------------------------------------
// tb_event_change_monitor
//   Directed vectors with hand-computed expectations for event_change_monitor
//   (WIDTH=32, FIFO_DEPTH=4). Inputs change 1 time unit after a rising edge
//   and outputs are checked there, away from the active edge.
// ----------------------------------------------------------------------------
module tb_event_change_monitor;

    logic        clk;
    logic        rst;
    logic [31:0] ev;
    logic        upd_valid;
    logic [63:0] upd_data;
    logic        upd_ready;
    logic [4:0]  upd_count;
    logic        overflow;
    logic        ovf_clr;

    int n_checks = 0;
    int n_errors = 0;

    event_change_monitor #(
        .WIDTH      (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ev        (ev),
        .upd_valid (upd_valid),
        .upd_data  (upd_data),
        .upd_ready (upd_ready),
        .upd_count (upd_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the whole visible output state.
    task automatic check_out(input string tag, input logic v, input logic [63:0] d,
                             input logic [4:0] c, input logic o);
        check({tag, ".valid"}, 64'(upd_valid), 64'(v));
        check({tag, ".data"},  upd_data,       d);
        check({tag, ".count"}, 64'(upd_count), 64'(c));
        check({tag, ".ovf"},   64'(overflow),  64'(o));
    endtask

    initial begin
        rst       = 1'b0;
        ev        = 32'h0;
        upd_ready = 1'b0;
        ovf_clr   = 1'b0;

        // ---- 1: reset state and initial snapshot --------------------------
        step();
        step();
        check_out("reset", 1'b0, 64'h0, 5'd0, 1'b0);
        rst = 1'b1;
        step();
        check_out("snap", 1'b1, 64'h0, 5'd1, 1'b0);
        step();
        check_out("snap_hold", 1'b1, 64'h0, 5'd1, 1'b0);
        upd_ready = 1'b1;
        step();
        check_out("snap_pop", 1'b0, 64'h0, 5'd0, 1'b0);
        step();
        check_out("snap_quiet", 1'b0, 64'h0, 5'd0, 1'b0);

        // ---- 2: change detection, 1 cycle latency -------------------------
        ev = 32'h5;
        step();
        check_out("chg5", 1'b1, 64'h5, 5'd1, 1'b0);
        step();                                   // ev steady: head popped, no new record
        check_out("steady5", 1'b0, 64'h0, 5'd0, 1'b0);
        ev = 32'hFFFF_FFFF;
        step();
        check_out("chgF", 1'b1, 64'h0000_0000_FFFF_FFFF, 5'd1, 1'b0);
        step();
        check_out("steadyF", 1'b0, 64'h0, 5'd0, 1'b0);

        // ---- 3: back-pressure, ordered drain ------------------------------
        upd_ready = 1'b0;
        ev = 32'h1; step();
        check_out("bp1", 1'b1, 64'h1, 5'd1, 1'b0);
        ev = 32'h2; step();
        check_out("bp2", 1'b1, 64'h1, 5'd2, 1'b0);
        ev = 32'h3; step();
        check_out("bp3", 1'b1, 64'h1, 5'd3, 1'b0);
        upd_ready = 1'b1;
        step();
        check_out("drain1", 1'b1, 64'h2, 5'd2, 1'b0);
        step();
        check_out("drain2", 1'b1, 64'h3, 5'd1, 1'b0);
        step();
        check_out("drain3", 1'b0, 64'h0, 5'd0, 1'b0);

        // ---- 4: overflow, sticky flag, clear, set-wins --------------------
        upd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ev = 32'h10 + 32'(i);
            step();
        end
        check_out("ovf_full", 1'b1, 64'h10, 5'd4, 1'b1);
        step();                                   // 0x15 held: no re-report, flag sticky
        check_out("ovf_sticky", 1'b1, 64'h10, 5'd4, 1'b1);
        ovf_clr = 1'b1;
        step();
        check_out("ovf_clr", 1'b1, 64'h10, 5'd4, 1'b0);
        ev = 32'h16;                              // drop and clear on the same edge
        step();
        check_out("ovf_setwins", 1'b1, 64'h10, 5'd4, 1'b1);
        step();                                   // 0x16 held, clear now takes effect
        check_out("ovf_clr2", 1'b1, 64'h10, 5'd4, 1'b0);
        ovf_clr = 1'b0;

        // ---- 5: full with simultaneous pop and push -----------------------
        upd_ready = 1'b1;
        ev = 32'h20;
        step();
        check_out("full_pp", 1'b1, 64'h11, 5'd4, 1'b0);
        step();
        check_out("pp_drain1", 1'b1, 64'h12, 5'd3, 1'b0);
        step();
        check_out("pp_drain2", 1'b1, 64'h13, 5'd2, 1'b0);
        step();
        check_out("pp_drain3", 1'b1, 64'h20, 5'd1, 1'b0);
        step();
        check_out("pp_empty", 1'b0, 64'h0, 5'd0, 1'b0);

        // ---- 6: async reset mid-stream ------------------------------------
        upd_ready = 1'b0;
        ev = 32'h30; step();
        ev = 32'h31; step();
        check_out("pre_rst", 1'b1, 64'h30, 5'd2, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 64'h0, 5'd0, 1'b0);
        #1 rst = 1'b1;
        step();
        check_out("post_rst_snap", 1'b1, 64'h31, 5'd1, 1'b0);
        step();
        check_out("post_rst_hold", 1'b1, 64'h31, 5'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
